// File: rtl/alu_md_pkg.sv
// Shared codes for the EX-stage ALU control and the mult/div sequencer:
// ALU control codes, funct/ALUop encodings, HI/LO select and FSM states.
package alu_md_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_MULT = 4'b0011;
   localparam logic [3:0] ALU_DIV  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_NOR  = 4'b1001;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;
   localparam logic [3:0] ALU_ADDU = 4'b1101;
   localparam logic [3:0] ALU_SUBU = 4'b1110;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   localparam logic [1:0] ALUOP_LDST = 2'b00;
   localparam logic [1:0] ALUOP_BR   = 2'b01;
   localparam logic [1:0] ALUOP_R    = 2'b10;
   localparam logic [1:0] ALUOP_RSV  = 2'b11;

   localparam logic [1:0] HILO_ALU = 2'b00;
   localparam logic [1:0] HILO_HI  = 2'b01;
   localparam logic [1:0] HILO_LO  = 2'b10;

   typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

   function automatic logic is_md_func(input logic [5:0] f);
      return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
   endfunction

   function automatic logic is_hilo_func(input logic [5:0] f);
      return f inside {F_MFHI, F_MFLO};
   endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// Pipeline-facing bundle of the ALU control / mult-div block.
// master = EX pipeline stage, slave = alu_md_control.
interface alu_md_control_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
);
   logic              valid_in;
   logic [1:0]        ALUop;
   logic [5:0]        func;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [CTRL_W-1:0] ALU_Control;
   logic [1:0]        hilo_sel;
   logic              illegal_op;
   logic              stall;
   logic              busy;
   logic              md_done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output valid_in, ALUop, func, rs_val, rt_val,
      input  ALU_Control, hilo_sel, illegal_op, stall, busy, md_done, hi, lo
   );

   modport slave (
      input  valid_in, ALUop, func, rs_val, rt_val,
      output ALU_Control, hilo_sel, illegal_op, stall, busy, md_done, hi, lo
   );
endinterface

// File: rtl/alu_md_control_core.sv
// One radix-2 iteration per cycle on unsigned magnitudes: shift-add multiply
// or restoring shift-subtract divide, plus the iteration counter.
module md_iter_core #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_is_div,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_acc,
   output logic [DATA_W-1:0] o_q,
   output logic [CNT_W-1:0]  o_cnt
);
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_b;
   logic              r_is_div;
   logic [CNT_W-1:0]  r_cnt;

   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W+1:0] w_diff;

   // {r_acc,r_q} is the product (mult) or {remainder,quotient} (div).
   assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
   assign w_shift = {r_acc, r_q[DATA_W-1]};
   assign w_diff  = {1'b0, w_shift} - {2'b00, r_b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_q      <= '0;
         r_b      <= '0;
         r_is_div <= 1'b0;
         r_cnt    <= '0;
      end else if (i_load) begin
         r_acc    <= '0;
         r_q      <= i_a;
         r_b      <= i_b;
         r_is_div <= i_is_div;
         r_cnt    <= CNT_W'(DATA_W);
      end else if (i_step) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_is_div) begin
            if (w_diff[DATA_W+1:DATA_W] == 2'b00) begin
               r_acc <= w_diff[DATA_W-1:0];
               r_q   <= {r_q[DATA_W-2:0], 1'b1};
            end else begin
               r_acc <= w_shift[DATA_W-1:0];
               r_q   <= {r_q[DATA_W-2:0], 1'b0};
            end
         end else begin
            r_acc <= w_sum[DATA_W:1];
            r_q   <= {w_sum[0], r_q[DATA_W-1:1]};
         end
      end
   end

   assign o_acc = r_acc;
   assign o_q   = r_q;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control decode plus the HI/LO-owning mult/div sequencer
// (sign handling, FSM, stall generation).
module alu_md_control #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   alu_md_control_if.slave bus
);
   import alu_md_pkg::*;

   localparam int CNT_W = $clog2(DATA_W + 1);

   md_state_t         r_state;
   logic              r_busy, r_md_done, r_is_div, r_div0, r_neg_q, r_neg_r;
   logic [DATA_W-1:0] r_hi, r_lo, r_rs_raw;

   logic [3:0]          w_ctrl;
   logic [1:0]          w_sel;
   logic                w_illegal, w_rtype, w_md_op, w_hilo_rd, w_accept, w_step;
   logic                w_signed, w_is_div, w_a_neg, w_b_neg, w_div0;
   logic [DATA_W-1:0]   w_a_mag, w_b_mag, w_acc, w_q, w_quo, w_rem;
   logic [2*DATA_W-1:0] w_prod;
   logic [CNT_W-1:0]    w_cnt;

   always_comb begin
      w_ctrl    = ALU_AND;
      w_sel     = HILO_ALU;
      w_illegal = 1'b0;
      unique case (bus.ALUop)
         ALUOP_LDST: w_ctrl = ALU_ADD;
         ALUOP_BR:   w_ctrl = ALU_SUB;
         ALUOP_RSV:  w_ctrl = ALU_AND;
         ALUOP_R: begin
            case (bus.func)
               F_ADD:           w_ctrl = ALU_ADD;
               F_ADDU:          w_ctrl = ALU_ADDU;
               F_SUB:           w_ctrl = ALU_SUB;
               F_SUBU:          w_ctrl = ALU_SUBU;
               F_AND:           w_ctrl = ALU_AND;
               F_OR:            w_ctrl = ALU_OR;
               F_XOR:           w_ctrl = ALU_XOR;
               F_NOR:           w_ctrl = ALU_NOR;
               F_SLT:           w_ctrl = ALU_SLT;
               F_SLTU:          w_ctrl = ALU_SLTU;
               F_SLL:           w_ctrl = ALU_SLL;
               F_SRL:           w_ctrl = ALU_SRL;
               F_SRA:           w_ctrl = ALU_SRA;
               F_MULT, F_MULTU: w_ctrl = ALU_MULT;
               F_DIV, F_DIVU:   w_ctrl = ALU_DIV;
               F_MFHI:          w_sel  = HILO_HI;
               F_MFLO:          w_sel  = HILO_LO;
               default:         w_illegal = bus.valid_in;
            endcase
         end
         default: w_ctrl = ALU_AND;
      endcase
   end

   assign w_rtype   = (bus.ALUop == ALUOP_R);
   assign w_md_op   = bus.valid_in & w_rtype & is_md_func(bus.func);
   assign w_hilo_rd = bus.valid_in & w_rtype & is_hilo_func(bus.func);

   // Unsigned variants have funct bit 0 set; divides have funct bit 1 set.
   assign w_signed = ~bus.func[0];
   assign w_is_div = bus.func[1];
   assign w_a_neg  = w_signed & bus.rs_val[DATA_W-1];
   assign w_b_neg  = w_signed & bus.rt_val[DATA_W-1];
   assign w_a_mag  = w_a_neg ? -bus.rs_val : bus.rs_val;
   assign w_b_mag  = w_b_neg ? -bus.rt_val : bus.rt_val;
   assign w_div0   = w_is_div & (bus.rt_val == '0);

   // FIX is the last busy cycle, so a waiting md_op is taken on the FIX edge.
   assign w_accept = w_md_op & ((r_state == IDLE) | (r_state == FIX));
   assign w_step   = (r_state == CALC);

   md_iter_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_step   (w_step),
      .i_is_div (w_is_div),
      .i_a      (w_a_mag),
      .i_b      (w_b_mag),
      .o_acc    (w_acc),
      .o_q      (w_q),
      .o_cnt    (w_cnt)
   );

   assign w_prod = r_neg_q ? -{w_acc, w_q} : {w_acc, w_q};
   assign w_quo  = r_neg_q ? -w_q : w_q;
   assign w_rem  = r_neg_r ? -w_acc : w_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_md_done <= 1'b0;
         r_is_div  <= 1'b0;
         r_div0    <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_rs_raw  <= '0;
      end else begin
         r_md_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
            end
            CALC: if (w_cnt == CNT_W'(1)) r_state <= FIX;
            FIX: begin
               r_md_done <= 1'b1;
               r_state   <= IDLE;
               r_busy    <= 1'b0;
               if (r_div0) begin
                  r_hi <= r_rs_raw;
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
            end
            default: r_state <= IDLE;
         endcase
         // Placed after the case so an accept overrides FIX's return to IDLE.
         if (w_accept) begin
            r_state  <= w_div0 ? FIX : CALC;
            r_busy   <= 1'b1;
            r_is_div <= w_is_div;
            r_div0   <= w_div0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_rs_raw <= bus.rs_val;
         end
      end
   end

   assign bus.ALU_Control = CTRL_W'(w_ctrl);
   assign bus.hilo_sel    = w_sel;
   assign bus.illegal_op  = w_illegal;
   assign bus.stall       = r_busy & (w_hilo_rd | (w_md_op & (r_state != FIX)));
   assign bus.busy        = r_busy;
   assign bus.md_done     = r_md_done;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
Second-generation ALU control for the MIPS32 datapath.
- Decodes ALUop/func into a widened ALU control code. The code space now covers unsigned, logical and shift variants.
- Contains a radix-2 iterative multiply/divide sequencer that owns the HI/LO registers.
- Raises a stall so the pipeline holds while a mult/div is in flight.
- Sits in EX, between the main control unit and the ALU and operand muxes.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
CTRL_W, 4, ALU control code width; minimum 4.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
valid_in  in  1  instruction in EX is valid.
ALUop  in  2  from main control: 00 = ld/st, 01 = branch, 10 = R-type, 11 = reserved.
func  in  6  R-type funct field.
rs_val  in  DATA_W  operand A (dividend / multiplicand).
rt_val  in  DATA_W  operand B (divisor / multiplier).
ALU_Control  out  CTRL_W  ALU operation code, combinational.
hilo_sel  out  2  00 = ALU result, 01 = HI, 10 = LO; combinational.
illegal_op  out  1  unknown func with ALUop = 10 and valid_in high; combinational.
stall  out  1  hold IF/ID/EX; combinational.
busy  out  1  sequencer not IDLE; registered.
md_done  out  1  one-cycle pulse when HI/LO are written; registered.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.

Behaviour:
- Reset (async, immediate): state = IDLE, hi = lo = 0, busy = 0, md_done = 0, counter = 0, internal operand registers = 0.
- Decode (combinational, zero latency):
  - ALUop 00 -> ADD 0010.
  - ALUop 01 -> SUB 0110.
  - ALUop 11 -> AND 0000.
  - ALUop 10, func to code:
    - add 100000 -> 0010
    - addu 100001 -> 1101
    - sub 100010 -> 0110
    - subu 100011 -> 1110
    - and 100100 -> 0000
    - or 100101 -> 0001
    - xor 100110 -> 1000
    - nor 100111 -> 1001
    - slt 101010 -> 0111
    - sltu 101011 -> 1010
    - sll 000000 -> 0101
    - srl 000010 -> 1011
    - sra 000011 -> 1100
    - mult 011000 / multu 011001 -> 0011
    - div 011010 / divu 011011 -> 0100
    - mfhi 010000 -> 0000, hilo_sel = 01
    - mflo 010010 -> 0000, hilo_sel = 10
    - any other func -> 0000, illegal_op = 1
- md_op = valid_in & ALUop == 10 & func in {mult, multu, div, divu}.
- hilo_rd = valid_in & ALUop == 10 & func in {mfhi, mflo}.
- FSM states: IDLE, CALC, FIX.
  - IDLE: on md_op, register operands (signed ops use magnitudes and record the result signs), set counter = DATA_W, go to CALC.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; at counter == 1, go to FIX.
  - FIX: apply signs, write hi/lo, pulse md_done next cycle, go to IDLE.
- Latency: issue edge E0. Iterations occur on E1..E_DATA_W. HI/LO are written on E_DATA_W+1. busy is high for DATA_W+1 cycles.
- Results:
  - mult: {hi,lo} = 2·DATA_W-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - MIN/-1: lo = 0x80000000, hi = 0, no trap.
  - Divide by zero: skip CALC, go IDLE -> FIX directly. hi = rs_val, lo = all ones. Latency is 2 edges.
- stall = busy & (md_op | hilo_rd). Other ops proceed while the sequencer runs.
- A stalled md_op is accepted on the edge where FIX returns to IDLE. In that cycle stall = 0, because busy drops only after the FIX edge. No bubble is added between back-to-back mult/div.
- md_op in IDLE is taken immediately; stall is not raised for it. The issuing instruction's EX write-back is suppressed by the main control, because mult/div write no GPR.
- Reset mid-operation aborts the op and zeroes hi/lo; no md_done.
- valid_in low: md_op is ignored and ALU_Control still decodes.

Decomposition:
- Package alu_md_pkg:
  - CTRL_W code localparams: ALU_AND … ALU_SUBU.
  - func localparams.
  - ALUop localparams.
  - State enum IDLE/CALC/FIX.
  - HILO_SEL codes.
- Sub-module md_iter_core: the datapath for one iteration step (mul/div select, remainder/accumulator registers, counter).
- alu_md_control keeps the decode, FSM, sign handling and hilo registers.

Test Plan:
- Decode sweep: ALUop = 10, every listed func -> exact ALU_Control/hilo_sel. func = 111111 -> 0000 with illegal_op = 1. ALUop 00/01/11 -> 0010 / 0110 / 0000.
- mult 7 × -3 -> after 33 edges hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; md_done is a single pulse; busy is high for exactly 33 cycles.
- divu 0xFFFFFFFF / 10 -> lo = 0x19999999, hi = 5. div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. div 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- div 123 / 0 -> 2 edges later hi = 123, lo = 0xFFFFFFFF, md_done = 1.
- Hazards while busy:
  - add issued -> stall = 0.
  - mflo issued -> stall = 1 until the FIX edge, then it sees the new lo.
  - Back-to-back multu issued during busy -> accepted on the FIX edge; both results are correct.
- Assert rst at CALC cycle 10 -> immediately busy = 0, hi = lo = 0, no md_done. A new mult after reset completes normally.
